// File: rtl/comp_mult_cfg_seq.sv
// Register-file initiator that programs comp_mult_top and then polls it for completion.
// Optional poll timeout is compiled in with COMP_MULT_CFG_SEQ_TIMEOUT_EN.
module comp_mult_cfg_seq #(
  parameter int SYS_AW   = 16,
  parameter int REG_DW   = 32,
  parameter int RF_BADDR = 0,
  parameter int TO_W     = 16
) (
  input  logic              clk,
  input  logic              sw_rst,
  input  logic              start,
  input  logic [SYS_AW-1:0] op1_ba,
  input  logic [SYS_AW-1:0] op2_ba,
  input  logic [SYS_AW-1:0] res_ba,
  input  logic [REG_DW-1:0] nr_op,
  input  logic [TO_W-1:0]   to_limit,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [SYS_AW-1:0] rf_addr,
  output logic              rf_wr,
  output logic [REG_DW-1:0] rf_cfg,
  input  logic [REG_DW-1:0] rf_sts
);

  typedef enum logic [2:0] {
    IDLE, WR_OP1, WR_OP2, WR_RES, WR_NR, WR_GO, SETTLE, POLL
  } state_t;

  localparam logic [SYS_AW-1:0] A_OP1 = SYS_AW'(RF_BADDR);
  localparam logic [SYS_AW-1:0] A_OP2 = SYS_AW'(RF_BADDR + 1);
  localparam logic [SYS_AW-1:0] A_RES = SYS_AW'(RF_BADDR + 2);
  localparam logic [SYS_AW-1:0] A_NR  = SYS_AW'(RF_BADDR + 3);
  localparam logic [SYS_AW-1:0] A_GO  = SYS_AW'(RF_BADDR + 4);

  state_t            r_state, w_state_nxt;
  logic [SYS_AW-1:0] r_op2, r_res;
  logic [REG_DW-1:0] r_nr;
  logic              r_armed, w_armed_nxt;
  logic [SYS_AW-1:0] w_addr_nxt;
  logic              w_wr_nxt, w_busy_nxt, w_done_nxt, w_to_nxt;
  logic [REG_DW-1:0] w_cfg_nxt;
  logic              w_accept, w_complete, w_hit;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_complete = r_armed && rf_sts[0];

`ifdef COMP_MULT_CFG_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] r_to, r_cnt, w_cnt_inc, w_cnt_nxt;

  // Saturating count of POLL cycles; limit 0 disables the timeout.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_hit     = (r_to != '0) && (w_cnt_inc >= r_to);

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      r_to  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) r_to <= to_limit;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_accept)             w_cnt_nxt = '0;
    else if (r_state == POLL) w_cnt_nxt = w_cnt_inc;
  end
`else
  logic w_unused_to;
  assign w_hit       = 1'b0;
  assign w_unused_to = ^to_limit;
`endif

  logic w_unused_sts;
  assign w_unused_sts = ^rf_sts[REG_DW-1:1];

  // Next-cycle bus values are computed here and registered, so every output is a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = '0;
    w_wr_nxt    = 1'b0;
    w_cfg_nxt   = '0;
    w_busy_nxt  = busy;
    w_done_nxt  = 1'b0;
    w_to_nxt    = 1'b0;
    w_armed_nxt = r_armed;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = WR_OP1;
        w_addr_nxt  = A_OP1;
        w_wr_nxt    = 1'b1;
        w_cfg_nxt   = REG_DW'(op1_ba);
        w_busy_nxt  = 1'b1;
        w_armed_nxt = 1'b0;
      end
      WR_OP1: begin
        w_state_nxt = WR_OP2;
        w_addr_nxt  = A_OP2;
        w_wr_nxt    = 1'b1;
        w_cfg_nxt   = REG_DW'(r_op2);
      end
      WR_OP2: begin
        w_state_nxt = WR_RES;
        w_addr_nxt  = A_RES;
        w_wr_nxt    = 1'b1;
        w_cfg_nxt   = REG_DW'(r_res);
      end
      WR_RES: begin
        w_state_nxt = WR_NR;
        w_addr_nxt  = A_NR;
        w_wr_nxt    = 1'b1;
        w_cfg_nxt   = r_nr;
      end
      WR_NR: begin
        w_state_nxt = WR_GO;
        w_addr_nxt  = A_GO;
        w_wr_nxt    = 1'b1;
        w_cfg_nxt   = REG_DW'(1);
      end
      WR_GO: begin
        w_state_nxt = SETTLE;
        w_addr_nxt  = A_GO;
      end
      SETTLE: begin
        w_state_nxt = POLL;
        w_addr_nxt  = A_GO;
      end
      POLL: begin
        // Only a 0->1 transition of the status bit counts; completion beats timeout.
        if (w_complete) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_armed_nxt = 1'b0;
        end else if (w_hit) begin
          w_state_nxt = IDLE;
          w_to_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_armed_nxt = 1'b0;
        end else begin
          w_addr_nxt  = A_GO;
          w_armed_nxt = r_armed | ~rf_sts[0];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sw_rst) begin
      r_state <= IDLE;
      r_op2   <= '0;
      r_res   <= '0;
      r_nr    <= '0;
      r_armed <= 1'b0;
      rf_addr <= '0;
      rf_wr   <= 1'b0;
      rf_cfg  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op2 <= op2_ba;
        r_res <= res_ba;
        r_nr  <= nr_op;
      end
      r_state <= w_state_nxt;
      r_armed <= w_armed_nxt;
      rf_addr <= w_addr_nxt;
      rf_wr   <= w_wr_nxt;
      rf_cfg  <= w_cfg_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      timeout <= w_to_nxt;
    end
  end

endmodule

// File: tb/tb_comp_mult_cfg_seq.sv
// Scoreboard bench for comp_mult_cfg_seq: stimulus queues cycle-stamped bus writes and
// done/timeout events; a negedge monitor matches every DUT write/pulse against the queue.
module tb_comp_mult_cfg_seq;

  logic        clk = 1'b0;
  logic        sw_rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op1_ba = '0, op2_ba = '0, res_ba = '0;
  logic [31:0] nr_op = '0;
  logic [15:0] to_limit = '0;
  logic        busy, done, timeout, rf_wr;
  logic [15:0] rf_addr;
  logic [31:0] rf_cfg;
  logic [31:0] rf_sts = '0;

  comp_mult_cfg_seq dut (
    .clk(clk), .sw_rst(sw_rst), .start(start),
    .op1_ba(op1_ba), .op2_ba(op2_ba), .res_ba(res_ba), .nr_op(nr_op),
    .to_limit(to_limit), .busy(busy), .done(done), .timeout(timeout),
    .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_cfg(rf_cfg), .rf_sts(rf_sts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;  // 0 write, 1 done, 2 timeout
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   cs;
  exp_t mon_e;
  int   mon_k;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rf_wr || done || timeout) begin
      total++;
      mon_k = rf_wr ? 0 : (done ? 1 : 2);
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: cyc=%0d wr=%b addr=%0d cfg=%0d done=%b timeout=%b, want nothing",
                 cyc, rf_wr, rf_addr, rf_cfg, done, timeout);
      end else begin
        mon_e = q.pop_front();
        if (mon_k != mon_e.kind || cyc != mon_e.cyc || (done && timeout) ||
            (mon_e.kind == 0 && (rf_addr != mon_e.addr || rf_cfg != mon_e.data)) ||
            (mon_e.kind != 0 && busy)) begin
          bad++;
          $display("FAIL bus_event: got kind=%0d cyc=%0d addr=%0d cfg=%0d busy=%b dn=%b to=%b, want kind=%0d cyc=%0d addr=%0d cfg=%0d busy=0",
                   mon_k, cyc, rf_addr, rf_cfg, busy, done, timeout,
                   mon_e.kind, mon_e.cyc, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pushw(input int c, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc = c; e.kind = 0; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic pushev(input int c, input int k);
    exp_t e;
    e.cyc = c; e.kind = k; e.addr = '0; e.data = '0;
    q.push_back(e);
  endtask

  // Start a job in the current cycle; expect the first nw writes in the following cycles.
  task automatic go(input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3,
                    input logic [31:0] nr, input logic [15:0] tl, input int nw);
    logic [31:0] d [5];
    d[0] = {16'h0, a1}; d[1] = {16'h0, a2}; d[2] = {16'h0, a3}; d[3] = nr; d[4] = 32'd1;
    start = 1'b1; op1_ba = a1; op2_ba = a2; res_ba = a3; nr_op = nr; to_limit = tl;
    cs = cyc;
    for (int i = 0; i < nw; i++) pushw(cs + 1 + i, 16'(i), d[i]);
    tick(1);
    start = 1'b0;
    op1_ba = 16'hdead; op2_ba = 16'hbeef; res_ba = 16'hcafe; nr_op = 32'h5555_5555;
    to_limit = 16'd1;
  endtask

  initial begin
    tick(3);
    chk("rst_addr", rf_addr, 0);
    chk("rst_wr", rf_wr, 0);
    chk("rst_cfg", rf_cfg, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    sw_rst = 1'b0;
    tick(2);

    // Job 1: basic writes, 20 POLL cycles of 0 then 1
    rf_sts = 0;
    go(16'd100, 16'd200, 16'd300, 32'd10, 16'd0, 5);
    chk("busy_after_start", busy, 1);
    tick(26);
    rf_sts = 1;
    pushev(cs + 28, 1);
    tick(1);
    chk("job1_busy_fall", busy, 0);

    // Job 2 back-to-back; stale 1 must not complete; start during POLL ignored
    go(16'd7, 16'd8, 16'd9, 32'd3, 16'd0, 5);
    tick(9);
    chk("job2_busy_poll", busy, 1);
    start = 1'b1; op1_ba = 16'd999;
    tick(1);
    start = 1'b0; op1_ba = 16'hdead;
    rf_sts = 0;
    tick(2);
    rf_sts = 1;
    pushev(cs + 14, 1);
    tick(2);

    // Job 3 with new op1; status stuck at 1 never completes
    go(16'd555, 16'd556, 16'd557, 32'd4, 16'd0, 5);
    tick(40);
    chk("stuck_busy", busy, 1);
    chk("stuck_done", done, 0);
    sw_rst = 1'b1;
    tick(1);
    chk("abort_busy", busy, 0);
    chk("abort_wr", rf_wr, 0);
    sw_rst = 1'b0;
    rf_sts = 0;
    tick(2);

    // Job 4: reset during WR_RES
    go(16'd11, 16'd12, 16'd13, 32'd14, 16'd0, 3);
    tick(2);
    sw_rst = 1'b1;
    tick(1);
    chk("midrst_wr", rf_wr, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", rf_addr, 0);
    sw_rst = 1'b0;
    tick(8);

    // Reset wins over start
    sw_rst = 1'b1; start = 1'b1; op1_ba = 16'd77;
    tick(1);
    chk("prio_busy", busy, 0);
    chk("prio_wr", rf_wr, 0);
    sw_rst = 1'b0; start = 1'b0;
    tick(3);

    // Job 5: full-width data, completion coinciding with a limit of 3
    go(16'h1234, 16'hABCD, 16'hFFFF, 32'hDEADBEEF, 16'd3, 5);
    tick(8);
    rf_sts = 1;
    pushev(cs + 10, 1);
    tick(1);
    chk("job5_busy_fall", busy, 0);
    rf_sts = 0;
    tick(2);

    // Job 6: limit 8 with status held at 0
    go(16'd1, 16'd2, 16'd3, 32'd4, 16'd8, 5);
`ifdef COMP_MULT_CFG_SEQ_TIMEOUT_EN
    pushev(cs + 15, 2);
    tick(19);
    chk("to_busy", busy, 0);
`else
    tick(19);
    chk("nolimit_busy", busy, 1);
`endif
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    tick(3);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp_mult_cfg_seq.md
COMP_MULT_CFG_SEQ -- requirements
Module: comp_mult_cfg_seq

Interface
REQ-001 SHALL have parameter SYS_AW, default 16, system/register-file address width.
REQ-002 SHALL have parameter REG_DW, default 32, register-file data width.
REQ-003 SHALL have parameter RF_BADDR, default 0, register-file base address.
REQ-004 SHALL have parameter TO_W, default 16, poll timeout counter width.
REQ-005 SHALL have port clk  in  1  system clock; one clock, all logic on rising edge.
REQ-006 SHALL have port sw_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  in  1  one-cycle request to run one job.
REQ-008 SHALL have port op1_ba  in  SYS_AW  operand-1 base address.
REQ-009 SHALL have port op2_ba  in  SYS_AW  operand-2 base address.
REQ-010 SHALL have port res_ba  in  SYS_AW  result base address.
REQ-011 SHALL have port nr_op  in  REG_DW  number of complex operations.
REQ-012 SHALL have port to_limit  in  TO_W  poll timeout in cycles; 0 = no timeout.
REQ-013 SHALL have port busy  out  1  job in progress.
REQ-014 SHALL have port done  out  1  one-cycle pulse, job completed.
REQ-015 SHALL have port timeout  out  1  one-cycle pulse, job abandoned.
REQ-016 SHALL have port rf_addr  out  SYS_AW  register-file address.
REQ-017 SHALL have port rf_wr  out  1  register-file write enable (0 = read).
REQ-018 SHALL have port rf_cfg  out  REG_DW  register-file write data.
REQ-019 SHALL have port rf_sts  in  REG_DW  register-file read data; bit 0 = multiplier done.

Function
REQ-020 SHALL be the initiator on the register-file bus of comp_mult_top; all outputs registered.
REQ-021 SHALL implement states IDLE, WR_OP1, WR_OP2, WR_RES, WR_NR, WR_GO, SETTLE, POLL.
REQ-022 SHALL, in IDLE with start=1, latch op1_ba, op2_ba, res_ba, nr_op, to_limit, assert busy, go to WR_OP1.
REQ-023 SHALL ignore start while busy=1; latched values stay unchanged.
REQ-024 SHALL drive one write per cycle, rf_wr=1: WR_OP1 addr RF_BADDR data op1_ba; WR_OP2 RF_BADDR+1 op2_ba; WR_RES RF_BADDR+2 res_ba; WR_NR RF_BADDR+3 nr_op; WR_GO RF_BADDR+4 data 1.
REQ-025 SHALL zero-extend SYS_AW addresses to REG_DW on rf_cfg.
REQ-026 SHALL present the WR_OP1 write on the bus in the cycle after start was sampled; the 5 writes occupy consecutive cycles.
REQ-027 SHALL, after WR_GO, drive rf_wr=0, rf_addr=RF_BADDR+4, rf_cfg=0 for SETTLE (1 cycle, rf_sts ignored), then POLL.
REQ-028 SHALL, in POLL, sample rf_sts[0] every cycle; set an armed flag on a 0 sample; complete on a 1 sample with armed set (rising edge only; a stale 1 does not complete).
REQ-029 SHALL, on completion, pulse done for exactly 1 cycle, deassert busy in the same cycle, return to IDLE.
REQ-030 SHALL count POLL cycles; when to_limit!=0 and count reaches to_limit without completion, pulse timeout 1 cycle, deassert busy, return to IDLE.
REQ-031 SHALL give completion priority when completion and timeout occur in the same cycle.
REQ-032 SHALL accept a new start in the cycle after done/timeout (back-to-back jobs).
REQ-033 SHALL saturate the POLL counter at all-ones (no wrap).

Reset
REQ-034 SHALL, with sw_rst=1 at a clock edge, go to IDLE; rf_addr=0, rf_wr=0, rf_cfg=0, busy=0, done=0, timeout=0, armed=0, counter=0.
REQ-035 SHALL abort any job on sw_rst mid-operation without completing pending writes or pulsing done/timeout.
REQ-036 SHALL give sw_rst priority over start in the same cycle.

Configuration
REQ-037 SHALL compile the timeout logic (REQ-030, REQ-031, REQ-033) only when macro COMP_MULT_CFG_SEQ_TIMEOUT_EN is defined.
REQ-038 SHALL, without COMP_MULT_CFG_SEQ_TIMEOUT_EN, poll indefinitely, tie timeout to 0, and ignore to_limit.

Verification
REQ-039 SHALL cover: start with op1_ba=100, op2_ba=200, res_ba=300, nr_op=10 -> writes (0,100),(1,200),(2,300),(3,10),(4,1) in 5 consecutive cycles starting 1 cycle after start.
REQ-040 SHALL cover: rf_sts[0] 0 for 20 POLL cycles then 1 -> done pulse 1 cycle, busy falls same cycle.
REQ-041 SHALL cover: rf_sts[0] stuck at 1 from SETTLE onward, to_limit=0 -> no done, busy stays 1.
REQ-042 SHALL cover (TIMEOUT_EN): to_limit=8, rf_sts[0]=0 -> timeout pulse after 8 POLL cycles, busy=0, no done.
REQ-043 SHALL cover: sw_rst asserted during WR_RES -> next edge rf_wr=0, busy=0, remaining writes never issued; new start then runs full sequence.
REQ-044 SHALL cover: start re-asserted during POLL with different op1_ba -> ignored; next job after done uses newly sampled values.
